// File: rtl/serial_parity_pkg.sv
// Shared definitions for the serial parity link (rx side today, tx side later).
package serial_parity_pkg;

  localparam int unsigned DefaultDataW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

endpackage

// File: rtl/serial_parity_if.sv
// Serial line plus received-word bus between the parity receiver and its consumer.
interface serial_parity_if #(
  parameter int unsigned DATA_W = 4
) ();

  logic              rx_in;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    input  rx_in,
    output data_out, valid, parity_err, frame_err, busy
  );

  modport slave (
    output rx_in,
    input  data_out, valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/serial_parity_rx_sync_2ff.sv
// Two-flop synchronizer; resets to 1 so an idle line is not mistaken for a start bit.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Receiver for start/data/parity/stop frames: mid-bit sampling, parity and framing checks.
module serial_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned BIT_CYCLES = 4,
  parameter bit          PARITY_ODD = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  serial_parity_if.master  bus
);

  localparam int unsigned CntW = $clog2(BIT_CYCLES);
  localparam int unsigned IdxW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(BIT_CYCLES / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(BIT_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_W - 1);

  logic rx_s;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rx_in),
    .q     (rx_s)
  );

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              acc_q, acc_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;
  logic              sample;

  // The start bit is sampled half a bit in; every later sample is one full bit after the previous.
  assign sample = (state_q == StStart) ? (cnt_q == HalfLast) : (cnt_q == FullLast);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    perr_d       = perr_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;

    if (state_q != StIdle && state_q != StBreak) begin
      cnt_d = sample ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = StStart;
          idx_d   = '0;
          acc_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (sample) begin
          if (rx_s) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (sample) begin
          shift_d             = shift_q >> 1;
          shift_d[DATA_W-1]   = rx_s;
          acc_d               = acc_q ^ rx_s;
          idx_d               = idx_q + 1'b1;
          if (idx_q == IdxLast) state_d = StParity;
        end
      end
      StParity: begin
        if (sample) begin
          perr_d  = acc_q ^ rx_s ^ PARITY_ODD;
          state_d = StStop;
        end
      end
      StStop: begin
        if (sample) begin
          data_d       = shift_q;
          parity_err_d = perr_q;
          frame_err_d  = !rx_s;
          valid_d      = 1'b1;
          busy_d       = 1'b0;
          state_d      = rx_s ? StIdle : StBreak;
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      acc_q        <= 1'b0;
      perr_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      perr_q       <= perr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Scoreboard bench: even- and odd-parity receivers share one serial line.
module tb_serial_parity_rx;

  localparam int unsigned DW  = 4;
  localparam int unsigned BC  = 4;
  localparam int          LAT = 29;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_e[$];
  exp_t q_o[$];

  serial_parity_if #(.DATA_W(DW)) bus_e ();
  serial_parity_if #(.DATA_W(DW)) bus_o ();

  assign bus_e.rx_in = rx;
  assign bus_o.rx_in = rx;

  serial_parity_rx #(.DATA_W(DW), .BIT_CYCLES(BC), .PARITY_ODD(1'b0)) dut_even (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_e)
  );

  serial_parity_rx #(.DATA_W(DW), .BIT_CYCLES(BC), .PARITY_ODD(1'b1)) dut_odd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_out(input string tag, input logic [DW-1:0] d, input logic pe,
                         input logic fe, input exp_t e);
    chk({tag, "_data"}, int'(d), int'(e.data));
    chk({tag, "_parity_err"}, int'(pe), int'(e.perr));
    chk({tag, "_frame_err"}, int'(fe), int'(e.ferr));
    chk({tag, "_latency_cycle"}, cyc, e.cyc);
  endtask

  always @(negedge clk) begin : mon_even
    exp_t e;
    if (bus_e.valid) begin
      if (q_e.size() == 0) chk("even_unexpected_valid", 1, 0);
      else begin
        e = q_e.pop_front();
        cmp_out("even", bus_e.data_out, bus_e.parity_err, bus_e.frame_err, e);
      end
    end
  end

  always @(negedge clk) begin : mon_odd
    exp_t e;
    if (bus_o.valid) begin
      if (q_o.size() == 0) chk("odd_unexpected_valid", 1, 0);
      else begin
        e = q_o.pop_front();
        cmp_out("odd", bus_o.data_out, bus_o.parity_err, bus_o.frame_err, e);
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BC) @(negedge clk);
  endtask

  // Called at a negedge; expected parity results are hand-computed per DUT.
  task automatic send_frame(input logic [DW-1:0] data, input logic pbit, input logic stop,
                            input logic perr_even, input logic perr_odd);
    logic [DW-1:0] d;
    q_e.push_back('{data: data, perr: perr_even, ferr: !stop, cyc: cyc + LAT});
    q_o.push_back('{data: data, perr: perr_odd,  ferr: !stop, cyc: cyc + LAT});
    d = data;
    drive_bit(1'b0);
    for (int i = 0; i < int'(DW); i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(stop);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic saw_busy;
    #1;
    chk("reset_data_out", int'(bus_e.data_out), 0);
    chk("reset_valid", int'(bus_e.valid), 0);
    chk("reset_parity_err", int'(bus_e.parity_err), 0);
    chk("reset_frame_err", int'(bus_e.frame_err), 0);
    chk("reset_busy", int'(bus_e.busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Good frame 0xA, parity 0
    send_frame(4'hA, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (6) @(negedge clk);

    // Reset during DATA after a word has been delivered
    rx = 1'b0;
    repeat (BC) @(negedge clk);
    rx = 1'b0;
    repeat (BC) @(negedge clk);
    rx = 1'b1;
    repeat (BC) @(negedge clk);
    chk("pre_reset_busy", int'(bus_e.busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_data_out", int'(bus_e.data_out), 0);
    chk("midreset_valid", int'(bus_e.valid), 0);
    chk("midreset_busy", int'(bus_e.busy), 0);
    chk("midreset_odd_parity_err", int'(bus_o.parity_err), 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(4'hA, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);

    // Parity error on the even receiver, clean on the odd one
    send_frame(4'h7, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (6) @(negedge clk);

    // False start: one-cycle low glitch
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    saw_busy = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus_e.busy) saw_busy = 1'b1;
    end
    chk("false_start_busy_pulse", int'(saw_busy), 1);
    chk("false_start_busy_clear", int'(bus_e.busy), 0);
    chk("false_start_data_held", int'(bus_e.data_out), 'h7);
    chk("false_start_perr_held", int'(bus_e.parity_err), 1);

    // Framing error, then line held low
    send_frame(4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    chk("break_busy", int'(bus_e.busy), 0);
    chk("break_frame_err_held", int'(bus_e.frame_err), 1);
    rx = 1'b1;
    repeat (4) @(negedge clk);

    // Back-to-back frames
    send_frame(4'h5, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(4'hC, 1'b0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 60 && (q_e.size() != 0 || q_o.size() != 0); i++) @(negedge clk);
    chk("even_queue_drained", q_e.size(), 0);
    chk("odd_queue_drained", q_o.size(), 0);
    chk("final_frame_err", int'(bus_e.frame_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
